// File: rtl/text_console_pkg.sv
// text_console_pkg: control codes and writer state shared by the text console RAM.
package text_console_pkg;
    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] BLANK  = 8'h20;
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} wr_state_t;
endpackage

// File: rtl/text_console_ram_if.sv
// text_console_ram_if: video read port and character stream of the text console.
interface text_console_ram_if #(
    parameter int COL_W  = 5,
    parameter int ROW_W  = 4,
    parameter int DATA_W = 16,
    parameter int CHAR_W = 8
);
    logic                     rd_en;
    logic [ROW_W-1:0]         rd_row;
    logic [COL_W-1:0]         rd_col;
    logic [DATA_W-1:0]        rd_data;
    logic                     ch_valid;
    logic                     ch_ready;
    logic [CHAR_W-1:0]        ch_data;
    logic [DATA_W-CHAR_W-1:0] ch_attr;
    modport master (output rd_en, rd_row, rd_col, ch_valid, ch_data, ch_attr, input rd_data, ch_ready);
    modport slave (input rd_en, rd_row, rd_col, ch_valid, ch_data, ch_attr, output rd_data, ch_ready);
endinterface

// File: rtl/text_console_mem.sv
// text_console_mem: simple dual-port cell RAM, read-first with a registered read port.
module text_console_mem #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[raddr];
endmodule

// File: rtl/text_console_ram.sv
// text_console_ram: text-mode cell buffer with cursor, wrap, hardware scroll and clear.
// Define TEXT_CONSOLE_TAB_EN to make 0x09 advance to the next 8-column tab stop.
module text_console_ram
    import text_console_pkg::*;
#(
    parameter int COLS   = 32,
    parameter int ROWS   = 16,
    parameter int DATA_W = 16,
    parameter int CHAR_W = 8,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    text_console_ram_if.slave bus,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             busy
);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int ATTR_W = DATA_W - CHAR_W;

    wr_state_t         state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, waddr;
    logic [ROW_W-1:0]  row_n, top, top_n, clr_row, clr_row_n;
    logic [COL_W-1:0]  col_n;
    logic [ATTR_W-1:0] attr_q, attr_n;
    logic [DATA_W-1:0] wdata;
    logic              we, adv;
`ifdef TEXT_CONSOLE_TAB_EN
    logic [COL_W:0]    tab_nx;
`endif

    // Logical to physical row: a single compare-and-subtract since both operands are < ROWS.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] t);
        logic [ROW_W:0] s;
        s = {1'b0, r} + {1'b0, t};
        return (s >= (ROW_W+1)'(ROWS)) ? ROW_W'(s - (ROW_W+1)'(ROWS)) : s[ROW_W-1:0];
    endfunction

    assign bus.ch_ready = (state == IDLE);
    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        row_n     = cur_row;
        col_n     = cur_col;
        top_n     = top;
        clr_row_n = clr_row;
        attr_n    = attr_q;
        adv       = 1'b0;
        we        = 1'b0;
        waddr     = {phys_row(cur_row, top), cur_col};
        wdata     = {bus.ch_attr, bus.ch_data};
`ifdef TEXT_CONSOLE_TAB_EN
        tab_nx    = ({1'b0, cur_col} | (COL_W+1)'(7)) + 1'b1;
`endif
        case (state)
            IDLE: if (bus.ch_valid) begin
                attr_n = bus.ch_attr;
                if (bus.ch_data >= CHAR_W'(BLANK)) begin
                    we    = 1'b1;
                    col_n = cur_col + 1'b1;
                    adv   = (cur_col == COL_W'(COLS - 1));
                end else begin
                    case (bus.ch_data)
                        CHAR_W'(CC_LF): begin col_n = '0; adv = 1'b1; end
                        CHAR_W'(CC_CR): col_n = '0;
                        CHAR_W'(CC_BS): col_n = (cur_col == '0) ? cur_col : cur_col - 1'b1;
                        CHAR_W'(CC_FF): begin
                            row_n   = '0;
                            col_n   = '0;
                            top_n   = '0;
                            cnt_n   = '0;
                            state_n = CLR_ALL;
                        end
`ifdef TEXT_CONSOLE_TAB_EN
                        CHAR_W'(CC_TAB): begin
                            col_n = tab_nx[COL_W-1:0];
                            adv   = (tab_nx >= (COL_W+1)'(COLS));
                        end
`endif
                        default: ;
                    endcase
                end
                // The old top row becomes the new bottom row once the window scrolls.
                if (adv) begin
                    if (cur_row == ROW_W'(ROWS - 1)) begin
                        top_n     = (top == ROW_W'(ROWS - 1)) ? '0 : top + 1'b1;
                        clr_row_n = top;
                        cnt_n     = '0;
                        state_n   = CLR_LINE;
                    end else begin
                        row_n = cur_row + 1'b1;
                    end
                end
            end
            CLR_LINE: begin
                we      = 1'b1;
                waddr   = {clr_row, cnt[COL_W-1:0]};
                wdata   = {attr_q, CHAR_W'(BLANK)};
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == ADDR_W'(COLS - 1)) ? IDLE : CLR_LINE;
            end
            CLR_ALL: begin
                we      = 1'b1;
                waddr   = cnt;
                wdata   = {attr_q, CHAR_W'(BLANK)};
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == ADDR_W'(ROWS * COLS - 1)) ? IDLE : CLR_ALL;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            cur_row <= '0;
            cur_col <= '0;
            top     <= '0;
            clr_row <= '0;
            attr_q  <= '0;
        end else begin
            cnt     <= cnt_n;
            cur_row <= row_n;
            cur_col <= col_n;
            top     <= top_n;
            clr_row <= clr_row_n;
            attr_q  <= attr_n;
        end

    text_console_mem #(.DEPTH(ROWS * COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .rd_en   (bus.rd_en),
        .raddr   ({phys_row(bus.rd_row, top), bus.rd_col}),
        .rd_data (bus.rd_data)
    );
endmodule

// File: tb/tb_text_console_ram.sv
// tb_text_console_ram: directed checks of the text console RAM with COLS=32, ROWS=4.
module tb_text_console_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    text_console_ram_if #(.COL_W(5), .ROW_W(2), .DATA_W(16), .CHAR_W(8)) bus ();

    text_console_ram #(.COLS(32), .ROWS(4), .DATA_W(16), .CHAR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds valid until accepted, returns the negedges spent waiting.
    task automatic send(input logic [7:0] c, input logic [7:0] a, output int waited);
        waited = 0;
        bus.ch_valid = 1'b1;
        bus.ch_data  = c;
        bus.ch_attr  = a;
        while (!bus.ch_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        bus.ch_valid = 1'b0;
        if (waited >= 1000) chk("send_timeout", 32'(waited), 32'd0);
    endtask

    task automatic rd(input int r, input int c, output logic [15:0] d);
        bus.rd_en  = 1'b1;
        bus.rd_row = 2'(r);
        bus.rd_col = 5'(c);
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic cur_chk(input string tag, input int r, input int c);
        chk({tag, "_row"}, 32'(cur_row), 32'(r));
        chk({tag, "_col"}, 32'(cur_col), 32'(c));
    endtask

    initial begin
        logic [15:0] d;
        int          w;
        int          n;
        int          ready_drops;
        bus.ch_valid = 1'b0;
        bus.ch_data  = '0;
        bus.ch_attr  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_row   = '0;
        bus.rd_col   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_ready", 32'(bus.ch_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        cur_chk("rst_cur", 0, 0);

        send(8'h41, 8'h07, w);
        send(8'h42, 8'h07, w);
        rd(0, 0, d); chk("ab_00", 32'(d), 32'h0741);
        rd(0, 1, d); chk("ab_01", 32'(d), 32'h0742);
        cur_chk("ab_cur", 0, 2);
        @(negedge clk);
        chk("rd_hold", 32'(bus.rd_data), 32'h0742);

        send(8'h0D, 8'h07, w);
        ready_drops = 0;
        for (int i = 0; i < 32; i++) begin
            if (!bus.ch_ready) ready_drops++;
            send(8'h78, 8'h07, w);
        end
        chk("wrap_ready_drops", 32'(ready_drops), 32'd0);
        for (int c = 0; c < 32; c++) begin
            rd(0, c, d); chk($sformatf("wrap_r0c%0d", c), 32'(d), 32'h0778);
        end
        cur_chk("wrap_cur", 1, 0);

        send(8'h43, 8'h07, w);
        send(8'h0A, 8'h07, w);
        send(8'h0A, 8'h07, w);
        for (int i = 0; i < 5; i++) send(8'h79, 8'h07, w);
        cur_chk("pre_scroll_cur", 3, 5);
        send(8'h0A, 8'h1E, w);
        bus.ch_attr = 8'h55;
        n = 0;
        while (!bus.ch_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("scroll_busy_cycles", 32'(n), 32'd32);
        for (int c = 0; c < 32; c++) begin
            rd(3, c, d); chk($sformatf("scroll_r3c%0d", c), 32'(d), 32'h1E20);
        end
        rd(0, 0, d); chk("scroll_old_r1", 32'(d), 32'h0743);
        rd(2, 4, d); chk("scroll_old_r3", 32'(d), 32'h0779);
        cur_chk("scroll_cur", 3, 0);

        send(8'h0C, 8'h07, w);
        cur_chk("ff_cur", 0, 0);
        chk("ff_busy", 32'(busy), 32'd1);
        send(8'h5A, 8'h07, w);
        chk("ff_wait_cycles", 32'(w), 32'd128);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++) begin
                rd(r, c, d);
                chk($sformatf("ff_r%0dc%0d", r, c), 32'(d), (r == 0 && c == 0) ? 32'h075A : 32'h0720);
            end
        cur_chk("ff_held_cur", 0, 1);

        send(8'h08, 8'h07, w);
        cur_chk("bs_cur", 0, 0);
        send(8'h08, 8'h07, w);
        cur_chk("bs_col0_cur", 0, 0);
        send(8'h0A, 8'h07, w);
        send(8'h0A, 8'h07, w);
        for (int i = 0; i < 9; i++) send(8'h71, 8'h07, w);
        cur_chk("pre_cr_cur", 2, 9);
        send(8'h0D, 8'h07, w);
        cur_chk("cr_cur", 2, 0);
        bus.ch_valid = 1'b1;
        bus.ch_data  = 8'h57;
        bus.ch_attr  = 8'h07;
        bus.rd_en    = 1'b1;
        bus.rd_row   = 2'd2;
        bus.rd_col   = 5'd0;
        @(negedge clk);
        bus.ch_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("rw_same_old", 32'(bus.rd_data), 32'h0771);
        rd(2, 0, d); chk("rw_same_new", 32'(d), 32'h0757);

        send(8'h0D, 8'h07, w);
        for (int i = 0; i < 3; i++) send(8'h6B, 8'h07, w);
        cur_chk("pre_tab_cur", 2, 3);
        send(8'h09, 8'h07, w);
`ifdef TEXT_CONSOLE_TAB_EN
        cur_chk("tab_cur", 2, 8);
`else
        cur_chk("tab_cur", 2, 3);
`endif

        send(8'h0C, 8'h07, w);
        repeat (10) @(negedge clk);
        chk("mid_clear_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.ch_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_data", 32'(bus.rd_data), 32'h0);
        cur_chk("arst_cur", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.ch_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
